// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) round helpers for the AES-128 inverse cipher.
// State layout is column-major: byte (row r, col c) sits at bits [127-8*(4c+r) -: 8].
package aes_pkg;

  localparam int NR        = 10;
  localparam int RK_ADDR_W = 4;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul09(input byte_t a);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic byte_t gmul0b(input byte_t a);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic byte_t gmul0d(input byte_t a);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic byte_t gmul0e(input byte_t a);
    byte_t x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r is rotated right by r: out(r,c) = in(r,(c-r) mod 4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Each column is multiplied by the circulant matrix {0E,0B,0D,09}.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    byte_t  a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
      o[119-32*c -: 8] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
      o[111-32*c -: 8] = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
      o[103-32*c -: 8] = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);
    end
    return o;
  endfunction

  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, 256-entry table.
module aes_inv_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry for input value v lives at bits [2047-8*v -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] idx;

  assign idx   = 11'd2047 - {in_i, 3'b000};
  assign out_o = INV_SBOX[idx -: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// fetched combinationally from the key-expansion block via rk_addr/rk_data.
// Optional macro AES_INV_ABORT_EN adds an 'abort' input that returns the core
// to IDLE from ROUND or DONE, discarding the block in flight.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, and pt_out
// stays stable there until out_ready. Leaving DONE takes one edge, so there is
// always one IDLE cycle before the next block can be accepted.
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
`ifdef AES_INV_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         ct_in,
  output logic [RK_ADDR_W-1:0] rk_addr,
  input  logic [127:0]         rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         pt_out,
  output logic                 busy
);

  fsm_e       state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  state_t     data_q, data_d;
  logic       abort_w;

  state_t shifted, subbed, keyed, mixed;

`ifdef AES_INV_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
  assign shifted = inv_shift_rows(data_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .in_i  (shifted[127-8*i -: 8]),
      .out_o (subbed[127-8*i -: 8])
    );
  end

  assign keyed  = add_round_key(subbed, rk_data);
  assign mixed  = inv_mix_columns(keyed);
  assign pt_out = data_q;

  // Next-state, round-key index and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_addr   = RK_ADDR_W'(NR);
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        // abort in IDLE blocks the accept for that cycle
        if (in_valid && !abort_w) begin
          data_d  = add_round_key(ct_in, rk_data);
          rnd_d   = 4'(NR - 1);
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        busy    = 1'b1;
        rk_addr = RK_ADDR_W'(rnd_q);
        if (abort_w) begin
          data_d  = '0;
          rnd_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (rnd_q == 4'd0) begin
          // final round has no InvMixColumns
          data_d  = keyed;
          state_d = ST_DONE;
        end else begin
          data_d = mixed;
          rnd_d  = rnd_q - 4'd1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        rk_addr   = '0;
        out_valid = !abort_w;
        if (abort_w) begin
          data_d  = '0;
          rnd_d   = 4'd0;
          state_d = ST_IDLE;
        end else if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        data_d  = '0;
        rnd_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, round counter and block register; reset discards any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= 4'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter using the FIPS-197 known-answer
// vectors (appendix C.1 and appendix B) with a round-key lookup model.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int key_sel;

  logic [127:0] keys_a [0:10];
  logic [127:0] keys_b [0:10];

  typedef struct {
    logic [127:0] ct;
    int           ksel;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [0:1];

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  // clock / reset block
  always #5 clk = ~clk;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  // model of the key-expansion block's combinational lookup port
  always_comb begin
    rk_data = '0;
    if (rk_addr <= 4'd10) rk_data = (key_sel == 1) ? keys_b[rk_addr] : keys_a[rk_addr];
  end

  // scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  // Present one block from IDLE; lat = edges after the accept edge until out_valid.
  task automatic run_block(input logic [127:0] ct, input int ksel, output int lat,
                           output logic [127:0] pt);
    key_sel  = ksel;
    ct_in    = ct;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ct_in    = '0;
    wait_out(lat);
    pt = pt_out;
  endtask

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat;
    int           n;
    int           cyc;
    int           nacc;
    int           nout;
    int           acc_cyc [0:1];
    logic [127:0] outs [0:1];
    logic [127:0] pt;
    logic         prev_busy;
    logic         seen;

    keys_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    keys_a[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    keys_a[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    keys_a[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    keys_a[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    keys_a[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    keys_a[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    keys_a[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    keys_a[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    keys_a[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    keys_a[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    keys_b[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys_b[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    keys_b[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    keys_b[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    keys_b[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    keys_b[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    keys_b[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    keys_b[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    keys_b[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    keys_b[9]  = 128'hac7766f319fadc2128d12941575c006e;
    keys_b[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{C1_CT, 0, C1_PT};
    vecs[1] = '{B_CT,  1, B_PT};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ct_in     = '0;
    key_sel   = 0;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_pt_out",    pt_out,          128'd0);
    check("rst_rk_addr",   128'(rk_addr),   128'd10);
    rst = 1'b0;
    step();

    // table-driven known-answer vectors, out_ready held high
    for (int i = 0; i < 2; i++) begin
      run_block(vecs[i].ct, vecs[i].ksel, lat, pt);
      // out_valid rises on the 10th edge after the accept edge (11 edges counting it)
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd10);
      check($sformatf("vec%0d_pt", i), pt, vecs[i].pt);
      step();
      check($sformatf("vec%0d_idle_ready", i), 128'(in_ready), 128'd1);
    end

    // rk_addr sequence 10,9,...,0 from the accept cycle through the final round
    key_sel  = 0;
    ct_in    = C1_CT;
    in_valid = 1'b1;
    check("rk_seq_10", 128'(rk_addr), 128'd10);
    for (int k = 9; k >= 0; k--) begin
      step();
      in_valid = 1'b0;
      check($sformatf("rk_seq_%0d", k), 128'(rk_addr), 128'(k));
    end
    wait_out(n);
    check("rk_seq_pt", pt_out, C1_PT);
    step();

    // backpressure: out_ready low for 20 cycles after out_valid
    out_ready = 1'b0;
    run_block(C1_CT, 0, lat, pt);
    check("bp_latency", 128'(lat), 128'd10);
    check("bp_pt", pt, C1_PT);
    for (int k = 0; k < 20; k++) begin
      step();
      check("bp_pt_hold",    pt_out,          C1_PT);
      check("bp_in_ready",   128'(in_ready),  128'd0);
      check("bp_out_valid",  128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready",  128'(in_ready),  128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);

    // back-to-back: in_valid and out_ready held high, key switches between blocks
    key_sel   = 0;
    ct_in     = C1_CT;
    in_valid  = 1'b1;
    prev_busy = busy;
    nacc      = 0;
    nout      = 0;
    cyc       = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    outs[0]   = '0;
    outs[1]   = '0;
    while (nout < 2 && cyc < 60) begin
      step();
      cyc++;
      if (busy && !prev_busy && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1) ct_in = B_CT;
        else in_valid = 1'b0;
      end
      prev_busy = busy;
      if (out_valid && nout < 2) begin
        outs[nout] = pt_out;
        nout++;
        key_sel = 1;
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(nacc), 128'd2);
    check("b2b_gap",     128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    check("b2b_pt0",     outs[0], C1_PT);
    check("b2b_pt1",     outs[1], B_PT);
    step();

    // asynchronous reset while the round counter is at 5
    key_sel  = 0;
    ct_in    = C1_CT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (rk_addr != 4'd5 && n < 20) begin
      step();
      n++;
    end
    check("mid_rst_reached_rnd5", 128'(rk_addr), 128'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready",  128'(in_ready),  128'd1);
    check("mid_rst_busy",      128'(busy),      128'd0);
    check("mid_rst_rk_addr",   128'(rk_addr),   128'd10);
    check("mid_rst_pt_out",    pt_out,          128'd0);
    step();
    rst = 1'b0;
    step();
    run_block(C1_CT, 0, lat, pt);
    check("post_rst_latency", 128'(lat), 128'd10);
    check("post_rst_pt",      pt, C1_PT);
    step();

`ifdef AES_INV_ABORT_EN
    // abort while the round counter is at 3
    key_sel  = 0;
    ct_in    = C1_CT;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (rk_addr != 4'd3 && n < 20) begin
      step();
      n++;
    end
    check("abort_reached_rnd3", 128'(rk_addr), 128'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_busy",     128'(busy),     128'd0);
    check("abort_pt_clear", pt_out,         128'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check("abort_no_out_valid", 128'(seen), 128'd0);

    // abort in IDLE blocks an accept
    ct_in    = C1_CT;
    in_valid = 1'b1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_idle_busy",     128'(busy),     128'd0);
    check("abort_idle_in_ready", 128'(in_ready), 128'd1);

    run_block(C1_CT, 0, lat, pt);
    check("post_abort_pt", pt, C1_PT);
    step();
`endif

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
